// File: rtl/pc_fetch_if.sv
// Fetch-side bus bundle for pc_fetch: memory request/response channel,
// instruction issue to decode, and retire feedback from execute.
interface pc_fetch_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            wb_valid;
  logic [1:0]      pc_src;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;

  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc,
    input  req_ready, rsp_valid, rsp_data, rsp_err, inst_ready, wb_valid, pc_src, imm, rs1
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc,
    output req_ready, rsp_valid, rsp_data, rsp_err, inst_ready, wb_valid, pc_src, imm, rs1
  );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch sequencer: requests the word at pc,
// hands it to decode, and applies the retiring instruction's pc_src select.
module pc_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_fetch_if.master      bus,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic [1:0]      halt_cause
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_BUS      = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [1:0]      cause_q, cause_d;
  logic            req_valid_q, req_valid_d;
  logic            inst_valid_q, inst_valid_d;
  logic            halted_q, halted_d;
  logic            retire_s;
  logic            illegal_s;
  logic [XLEN-1:0] jalr_sum_s;
  logic [XLEN-1:0] target_s;

  // Candidate next PC for whichever instruction retires this cycle
  always_comb begin
    jalr_sum_s = bus.rs1 + bus.imm;
    illegal_s  = 1'b0;
    case (bus.pc_src)
      2'b00:   target_s = pc_q + XLEN'(32'd4);
      2'b01:   target_s = pc_q + bus.imm;
      2'b10:   target_s = jalr_sum_s & {{(XLEN-1){1'b1}}, 1'b0};
      default: begin
        target_s  = pc_q;
        illegal_s = 1'b1;
      end
    endcase
  end

  // Next-state and next-value logic for the fetch sequencer
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    cause_d   = cause_q;
    retire_s  = 1'b0;

    case (state_q)
      S_REQ: begin
        // req_valid_q is low only in the first cycle out of reset
        if (req_valid_q && bus.req_ready) state_d = S_WAIT;
        else                              state_d = S_REQ;
      end
      S_WAIT: begin
        if (bus.rsp_valid && bus.rsp_err) begin
          cause_d = CAUSE_BUS;
          state_d = S_HALT;
        end else if (bus.rsp_valid) begin
          inst_d    = bus.rsp_data;
          inst_pc_d = pc_q;
          state_d   = S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ISSUE: begin
        if (inst_valid_q && bus.inst_ready && bus.wb_valid) retire_s = 1'b1;
        else if (inst_valid_q && bus.inst_ready)            state_d  = S_EXEC;
        else                                                 state_d  = S_ISSUE;
      end
      S_EXEC: begin
        if (bus.wb_valid) retire_s = 1'b1;
        else              state_d  = S_EXEC;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    if (retire_s) begin
      if (illegal_s) begin
        cause_d = CAUSE_ILLEGAL;
        state_d = S_HALT;
      end else if (target_s[1:0] != 2'b00) begin
        cause_d = CAUSE_MISALIGN;
        state_d = S_HALT;
      end else begin
        pc_d    = target_s;
        state_d = S_REQ;
      end
    end else begin
      pc_d = pc_q;
    end

    req_valid_d  = (state_d == S_REQ);
    inst_valid_d = (state_d == S_ISSUE);
    halted_d     = (state_d == S_HALT);
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_pc_q    <= RESET_PC;
      inst_q       <= 32'd0;
      cause_q      <= CAUSE_NONE;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_pc_q    <= inst_pc_d;
      inst_q       <= inst_d;
      cause_q      <= cause_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.req_valid  = req_valid_q;
  assign bus.req_addr   = pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign halt_cause     = cause_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus a randomized
// instruction stream checked against an arithmetic next-PC model.
module tb_pc_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        halted;
  logic [1:0]  halt_cause;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          req_hs = 0;
  int          inst_hs = 0;
  logic [31:0] ref_pc;

  pc_fetch_if #(.XLEN(32)) bus ();

  pc_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pc(pc), .halted(halted), .halt_cause(halt_cause)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) req_hs <= req_hs + 1;
    if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) inst_hs <= inst_hs + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Reference: next PC and resulting halt cause from the pc_src rules
  function automatic logic [1:0] model_next(input logic [31:0] cur, input logic [1:0] src,
                                            input logic [31:0] imm_v, input logic [31:0] rs1_v,
                                            output logic [31:0] nxt);
    logic [31:0] t;
    nxt = cur;
    if (src == 2'b11) return 2'b11;
    if (src == 2'b00)      t = cur + 32'd4;
    else if (src == 2'b01) t = cur + imm_v;
    else                   t = (rs1_v + imm_v) & 32'hFFFF_FFFE;
    if ((t % 32'd4) != 32'd0) return 2'b10;
    nxt = t;
    return 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = 32'd0; bus.rsp_err = 1'b0;
    bus.inst_ready = 1'b0; bus.wb_valid = 1'b0; bus.pc_src = 2'b00; bus.imm = 32'd0; bus.rs1 = 32'd0;
    tick();
    tick();
    ref_pc = RESET_PC;
  endtask

  task automatic do_fetch(input int hold, input logic err, input logic [31:0] data,
                          output logic [31:0] addr, output int at_cyc, output bit stable, output bit tmo);
    int n = 0;
    stable = 1'b1; tmo = 1'b0; addr = 32'd0; at_cyc = 0;
    bus.req_ready = 1'b0;
    while (bus.req_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    if (bus.req_valid !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    addr = bus.req_addr;
    at_cyc = cyc;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.req_valid !== 1'b1 || bus.req_addr !== addr) stable = 1'b0;
    end
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1; bus.rsp_data = data; bus.rsp_err = err;
    tick();
    bus.rsp_valid = 1'b0; bus.rsp_err = 1'b0; bus.rsp_data = $urandom;
  endtask

  task automatic do_issue(input int hold, input int wb_dly, input logic [1:0] src,
                          input logic [31:0] imm_v, input logic [31:0] rs1_v,
                          output logic [31:0] inst_o, output logic [31:0] pc_o,
                          output bit stable, output bit tmo);
    int n = 0;
    stable = 1'b1; tmo = 1'b0; inst_o = 32'd0; pc_o = 32'd0;
    bus.inst_ready = 1'b0;
    while (bus.inst_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    if (bus.inst_valid !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    inst_o = bus.inst;
    pc_o = bus.inst_pc;
    // Retire and response noise while decode stalls must have no effect
    bus.wb_valid = 1'b1; bus.pc_src = 2'b11; bus.imm = $urandom; bus.rsp_valid = 1'b1; bus.rsp_err = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.inst_valid !== 1'b1 || bus.inst !== inst_o || bus.inst_pc !== pc_o || halted !== 1'b0)
        stable = 1'b0;
    end
    bus.rsp_valid = 1'b0; bus.rsp_err = 1'b0;
    bus.inst_ready = 1'b1; bus.wb_valid = (wb_dly == 0); bus.pc_src = src; bus.imm = imm_v; bus.rs1 = rs1_v;
    tick();
    bus.inst_ready = 1'b0;
    if (wb_dly > 0) begin
      bus.wb_valid = 1'b0;
      for (int i = 1; i < wb_dly; i++) tick();
      bus.wb_valid = 1'b1;
      tick();
    end
    bus.wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    hold_reset();
    n_cmp++; if (bus.req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b expected 0", bus.req_valid); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_inst_valid: got %b expected 0", bus.inst_valid); end
    n_cmp++; if (halted !== 1'b0 || halt_cause !== 2'b00) begin n_bad++; $display("FAIL reset_halt: got %b/%b expected 0/00", halted, halt_cause); end
    n_cmp++; if (pc !== RESET_PC || bus.inst_pc !== RESET_PC) begin n_bad++; $display("FAIL reset_pc: got %h/%h expected %h", pc, bus.inst_pc, RESET_PC); end
    n_cmp++; if (bus.inst !== 32'd0) begin n_bad++; $display("FAIL reset_inst: got %h expected 0", bus.inst); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.req_valid !== 1'b1 || bus.req_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_first_req: got %b/%h expected 1/%h", bus.req_valid, bus.req_addr, RESET_PC); end
  endtask

  task automatic test_straight();
    logic [31:0] a, d, ins, ip, nx;
    logic [1:0]  cs;
    int c, prev_c;
    bit s1, s2, t1, t2;
    prev_c = 0;
    hold_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      do_fetch(0, 1'b0, d, a, c, s1, t1);
      do_issue(0, 0, 2'b00, 32'd0, 32'd0, ins, ip, s2, t2);
      cs = model_next(ref_pc, 2'b00, 32'd0, 32'd0, nx);
      n_cmp++; if (t1 || t2) begin n_bad++; $display("FAIL straight_timeout: got %b%b expected 00", t1, t2); end
      n_cmp++; if (a !== RESET_PC + 32'(4 * k)) begin n_bad++; $display("FAIL straight_addr: got %h expected %h", a, RESET_PC + 32'(4 * k)); end
      n_cmp++; if (ins !== d || ip !== a) begin n_bad++; $display("FAIL straight_inst: got %h@%h expected %h@%h", ins, ip, d, a); end
      if (k > 0) begin
        n_cmp++; if (c - prev_c !== 3) begin n_bad++; $display("FAIL straight_period: got %0d expected 3", c - prev_c); end
      end
      ref_pc = nx;
      n_cmp++; if (pc !== ref_pc || halt_cause !== cs) begin n_bad++; $display("FAIL straight_pc: got %h/%b expected %h/%b", pc, halt_cause, ref_pc, cs); end
      prev_c = c;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, d, ins, ip, nx;
    logic [1:0]  cs;
    int c, r0, i0;
    bit s1, s2, t1, t2;
    r0 = req_hs; i0 = inst_hs;
    d = $urandom;
    do_fetch(4, 1'b0, d, a, c, s1, t1);
    do_issue(3, 2, 2'b00, 32'd0, 32'd0, ins, ip, s2, t2);
    cs = model_next(ref_pc, 2'b00, 32'd0, 32'd0, nx);
    n_cmp++; if (t1 || t2) begin n_bad++; $display("FAIL bp_timeout: got %b%b expected 00", t1, t2); end
    n_cmp++; if (!s1) begin n_bad++; $display("FAIL bp_req_stable: got unstable expected stable addr %h", a); end
    n_cmp++; if (!s2) begin n_bad++; $display("FAIL bp_inst_stable: got unstable expected stable inst %h", ins); end
    n_cmp++; if (a !== ref_pc || ins !== d || ip !== ref_pc) begin n_bad++; $display("FAIL bp_data: got %h %h %h expected %h %h %h", a, ins, ip, ref_pc, d, ref_pc); end
    n_cmp++; if (req_hs - r0 !== 1 || inst_hs - i0 !== 1) begin n_bad++; $display("FAIL bp_counts: got %0d/%0d expected 1/1", req_hs - r0, inst_hs - i0); end
    ref_pc = nx;
    n_cmp++; if (pc !== ref_pc || halted !== 1'b0 || cs !== 2'b00) begin n_bad++; $display("FAIL bp_pc: got %h/%b expected %h/0", pc, halted, ref_pc); end
  endtask

  task automatic test_branch_jalr();
    logic [31:0] a, ins, ip;
    int c;
    bit s1, s2, t1, t2;
    hold_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_fetch(0, 1'b0, $urandom, a, c, s1, t1);
      do_issue(0, k % 2, 2'b00, 32'd0, 32'd0, ins, ip, s2, t2);
    end
    n_cmp++; if (pc !== 32'h8000_0010) begin n_bad++; $display("FAIL br_setup_pc: got %h expected 80000010", pc); end
    do_fetch(1, 1'b0, $urandom, a, c, s1, t1);
    do_issue(0, 0, 2'b01, 32'hFFFF_FFF8, 32'd0, ins, ip, s2, t2);
    n_cmp++; if (pc !== 32'h8000_0008) begin n_bad++; $display("FAIL br_branch_pc: got %h expected 80000008", pc); end
    do_fetch(0, 1'b0, $urandom, a, c, s1, t1);
    do_issue(1, 1, 2'b10, 32'd4, 32'h8000_0101, ins, ip, s2, t2);
    n_cmp++; if (pc !== 32'h8000_0104 || halted !== 1'b0) begin n_bad++; $display("FAIL br_jalr_pc: got %h/%b expected 80000104/0", pc, halted); end
    n_cmp++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h8000_0104) begin n_bad++; $display("FAIL br_jalr_req: got %b/%h expected 1/80000104", bus.req_valid, bus.req_addr); end
  endtask

  task automatic test_wrap();
    logic [31:0] a, ins, ip;
    int c;
    bit s1, s2, t1, t2;
    hold_reset();
    rst_n = 1'b1;
    do_fetch(0, 1'b0, $urandom, a, c, s1, t1);
    do_issue(0, 0, 2'b01, 32'h7FFF_FFFC, 32'd0, ins, ip, s2, t2);
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_setup_pc: got %h expected fffffffc", pc); end
    do_fetch(0, 1'b0, $urandom, a, c, s1, t1);
    do_issue(0, 0, 2'b00, 32'd0, 32'd0, ins, ip, s2, t2);
    n_cmp++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h0000_0000 || halted !== 1'b0) begin n_bad++; $display("FAIL wrap_req: got %b/%h/%b expected 1/00000000/0", bus.req_valid, bus.req_addr, halted); end
  endtask

  task automatic test_faults();
    logic [31:0] a, ins, ip;
    logic [1:0]  exp_cause [3] = '{2'b10, 2'b01, 2'b11};
    int c;
    bit s1, s2, t1, t2, leaked;
    for (int f = 0; f < 3; f++) begin
      hold_reset();
      rst_n = 1'b1;
      do_fetch(0, (f == 1), $urandom, a, c, s1, t1);
      if (f != 1) do_issue(0, f, (f == 0) ? 2'b01 : 2'b11, 32'd2, 32'd0, ins, ip, s2, t2);
      n_cmp++; if (halted !== 1'b1 || halt_cause !== exp_cause[f]) begin n_bad++; $display("FAIL fault%0d_cause: got %b/%b expected 1/%b", f, halted, halt_cause, exp_cause[f]); end
      n_cmp++; if (pc !== RESET_PC) begin n_bad++; $display("FAIL fault%0d_pc: got %h expected %h", f, pc, RESET_PC); end
      leaked = 1'b0;
      bus.req_ready = 1'b1; bus.inst_ready = 1'b1; bus.wb_valid = 1'b1; bus.pc_src = 2'b00; bus.rsp_data = $urandom;
      for (int i = 0; i < 8; i++) begin
        bus.rsp_valid = 1'(i % 2);
        tick();
        if (bus.req_valid !== 1'b0 || bus.inst_valid !== 1'b0 || halted !== 1'b1 || halt_cause !== exp_cause[f]) leaked = 1'b1;
      end
      n_cmp++; if (leaked) begin n_bad++; $display("FAIL fault%0d_absorb: got activity after halt expected none", f); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, d, ins, ip;
    int c, n;
    bit s1, s2, t1, t2, ok;
    hold_reset();
    rst_n = 1'b1;
    do_fetch(0, 1'b0, $urandom, a, c, s1, t1);
    do_issue(0, 0, 2'b00, 32'd0, 32'd0, ins, ip, s2, t2);
    n = 0;
    while (bus.req_valid !== 1'b1 && n < 8) begin tick(); n++; end
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pc !== RESET_PC || bus.req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_async_clear: got %h/%b expected %h/0", pc, bus.req_valid, RESET_PC); end
    tick();
    rst_n = 1'b1;
    bus.rsp_valid = 1'b1; bus.rsp_data = 32'hDEAD_BEEF; bus.rsp_err = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (bus.req_valid !== 1'b1 || bus.req_addr !== RESET_PC || bus.inst_valid !== 1'b0 || halted !== 1'b0) ok = 1'b0;
    end
    bus.rsp_valid = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_stale_rsp: got %b/%h expected 1/%h", bus.req_valid, bus.req_addr, RESET_PC); end
    d = $urandom;
    do_fetch(0, 1'b0, d, a, c, s1, t1);
    do_issue(0, 0, 2'b00, 32'd0, 32'd0, ins, ip, s2, t2);
    n_cmp++; if (ins !== d || ip !== RESET_PC) begin n_bad++; $display("FAIL mid_refetch: got %h@%h expected %h@%h", ins, ip, d, RESET_PC); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, ins, ip, nx, t, imm_v, rs1_v;
    logic [1:0]  src, cs;
    int c, errs;
    bit s1, s2, t1, t2;
    hold_reset();
    rst_n = 1'b1;
    errs = 0;
    for (int k = 0; k < 24; k++) begin
      src = 2'($urandom_range(0, 2));
      t = $urandom & 32'hFFFF_FFFC;
      imm_v = $urandom;
      rs1_v = $urandom;
      if (src == 2'b01) imm_v = t - ref_pc;
      if (src == 2'b10) rs1_v = t - imm_v + 32'($urandom_range(0, 1));
      d = $urandom;
      do_fetch($urandom_range(0, 2), 1'b0, d, a, c, s1, t1);
      do_issue($urandom_range(0, 2), $urandom_range(0, 2), src, imm_v, rs1_v, ins, ip, s2, t2);
      cs = model_next(ref_pc, src, imm_v, rs1_v, nx);
      n_cmp++;
      if (t1 || t2 || !s1 || !s2 || a !== ref_pc || ins !== d || ip !== ref_pc || pc !== nx || halt_cause !== cs) begin
        n_bad++;
        $display("FAIL rand%0d: got addr %h inst %h@%h pc %h cause %b expected %h %h@%h %h %b", k, a, ins, ip, pc, halt_cause, ref_pc, d, ref_pc, nx, cs);
      end
      ref_pc = nx;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_straight();
    test_backpressure();
    test_branch_jalr();
    test_wrap();
    test_faults();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch sequencer for the single-cycle core. It holds the architectural PC and issues fetch requests to instruction memory over a valid/ready request channel. It accepts the response and presents the instruction to decode. When execute retires the instruction, it consumes the 2-bit `pc_src` select from next-PC control and computes the following PC. It is the consumer end of the `pc_src` encoding.

## Interface
- `XLEN`, 32, address/data width of PC, `imm`, `rs1`.
- `RESET_PC`, 32'h8000_0000, PC loaded on reset.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  out  1  fetch request valid.
- `req_ready`  in  1  memory accepts request.
- `req_addr`  out  XLEN  fetch address (equals `pc`).
- `rsp_valid`  in  1  fetch response valid (memory never back-pressured).
- `rsp_data`  in  32  fetched instruction.
- `rsp_err`  in  1  bus error with response.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts instruction.
- `inst`  out  32  instruction word.
- `inst_pc`  out  XLEN  PC of `inst`.
- `wb_valid`  in  1  current instruction retired; `pc_src`/`imm`/`rs1` valid this cycle.
- `pc_src`  in  2  00 pc+4, 01 pc+imm, 10 rs1+imm, 11 illegal.
- `imm`  in  XLEN  immediate for branch/jump target.
- `rs1`  in  XLEN  rs1 value for jalr.
- `pc`  out  XLEN  current architectural PC.
- `halted`  out  1  sticky; fetch stopped.
- `halt_cause`  out  2  00 none, 01 bus error, 10 misaligned target, 11 illegal `pc_src`.

## Operation
- FSM states: REQ, WAIT, ISSUE, EXEC, HALT. Encoding is free. All outputs are registered or decoded from state only.
- REQ: `req_valid`=1, `req_addr`=`pc`, held stable until `req_valid & req_ready`, then go to WAIT.
- WAIT: `req_valid`=0. On `rsp_valid`:
  - If `rsp_err`=0, latch `rsp_data` into `inst` and go to ISSUE.
  - If `rsp_err`=1, set `halt_cause`=01 and go to HALT.
- `rsp_valid` in any state other than WAIT is ignored.
- ISSUE: `inst_valid`=1, with `inst` and `inst_pc` stable.
  - On `inst_ready` with `wb_valid`=0, go to EXEC.
  - On `inst_ready` with `wb_valid`=1 in the same cycle, perform the next-PC update immediately and go to REQ. This is the single-cycle retire path.
- EXEC: `inst_valid`=0. On `wb_valid`, perform the next-PC update and go to REQ.
- `wb_valid` is ignored in REQ, WAIT, and in ISSUE without `inst_ready`.
- Next-PC update, with modulo 2^XLEN wrap-around and no overflow flag:
  - 00: `pc`+4.
  - 01: `pc`+`imm`.
  - 10: (`rs1`+`imm`) & ~1.
  - 11: `pc` unchanged, `halt_cause`=11, go to HALT.
- If the computed target has bits [1:0] ≠ 0, `pc` is not updated, `halt_cause`=10, go to HALT.
- HALT is absorbing: all valids 0, `halted`=1, and only `rst_n` exits it.
- Outputs at reset:
  - `pc`=`inst_pc`=`RESET_PC`, `inst`=0.
  - `req_valid`=0, `inst_valid`=0, `halted`=0, `halt_cause`=00.
  - State = REQ.

## Timing
- `rst_n` low clears all state asynchronously. This holds mid-transaction: any outstanding request or response is abandoned, and a stale `rsp_valid` arriving after reset is ignored because the FSM is in REQ.
- First cycle after `rst_n` rises: `req_valid`=1, `req_addr`=`RESET_PC`.
- Minimum loop with zero-wait memory, `inst_ready` and `wb_valid` held high is 3 cycles per instruction:
  - REQ (handshake), WAIT (response), ISSUE (accept + retire).
  - New `pc` is visible the cycle after retire, with `req_valid`=1 that same cycle.
- `pc` changes only on a retire edge; `inst_pc` changes only on the response-accept edge.
- `halted` and `halt_cause` are visible the cycle after the triggering edge.

## Test plan
- Reset then straight-line fetch:
  - Stimulus: `req_ready`=1, 0-wait response, `pc_src`=00.
  - Required: `req_addr` sequence 0x8000_0000, 0x8000_0004, 0x8000_0008, one request every 3 cycles, `inst`/`inst_pc` matching.
- Back-pressure:
  - Stimulus: `req_ready`=0 for 4 cycles, `inst_ready`=0 for 3 cycles.
  - Required: `req_addr` and `inst` remain stable throughout; exactly one request and one issue occur.
- Branch and jalr:
  - Stimulus: `pc`=0x8000_0010, `pc_src`=01 with `imm`=-8; then `pc_src`=10 with `rs1`=0x8000_0101, `imm`=4.
  - Required: next PCs are 0x8000_0008, then 0x8000_0104 (the LSB clear takes 0x8000_0105 to 0x8000_0104; the result is word-aligned, so no halt).
- Fault cases:
  - Stimulus A: `pc_src`=01 with `imm`=2.
  - Required A: `halted`=1, `halt_cause`=10, `pc` unchanged.
  - Stimulus B: `rsp_err`=1.
  - Required B: `halt_cause`=01.
  - Stimulus C: `pc_src`=11.
  - Required C: `halt_cause`=11.
  - All cases: no further `req_valid` until reset.
- Reset mid-fetch:
  - Stimulus: assert `rst_n`=0 in WAIT, then `rsp_valid`=1 the cycle after release.
  - Required: the response is ignored and `req_valid`=1 with `req_addr`=0x8000_0000.
- Wrap-around:
  - Stimulus: `pc`=0xFFFF_FFFC with `pc_src`=00.
  - Required: next `req_addr`=0x0000_0000, no halt.
